port_ingress_framer: RTL

- Per-port ingress framing stage, instantiated once per port, directly upstream of each port input FIFO.
- Checks the sop/eop/vld packet stream from the port and writes tagged words {err, sop, eop, data} into the FIFO.
- Admits or drops each packet as a whole at sop, based on FIFO occupancy.
- Closes truncated or malformed packets with an error-eop word, so the enter arbiter downstream only sees well-formed frames.

---
 rtl/port_ingress_framer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/port_ingress_framer.sv
// Per-port ingress framer: validates sop/eop/vld beats, admits or drops whole packets, and closes bad packets with an error-eop word.
// Latency: one cycle from input beat to fifo_wr_en/fifo_din; at most one FIFO write per cycle.
// Backpressure: no ready to the port; fifo_almost_full drops packets at sop, or defers the closing word until the FIFO has room.
// Optional build macro PORT_FRAMER_STATS_EN: when defined, pkt_cnt/drop_cnt/err_cnt are real saturating counters, otherwise tied to 0.
module port_ingress_framer #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_LEN    = 256,
  parameter int LEN_W      = 9
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  fifo_almost_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH+2:0] fifo_din,
  output logic                  err_pulse,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           err_cnt
);

  // IDLE: between packets. PKT: admitted packet open in the FIFO.
  // CLOSE: closing error word owed, waiting for FIFO room. DROP: discarding until eop.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PKT   = 2'd1,
    CLOSE = 2'd2,
    DROP  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0]      MAX_LEN_L  = LEN_W'(MAX_LEN);
  localparam logic [DATA_WIDTH+2:0] CLOSE_WORD = {3'b101, {DATA_WIDTH{1'b0}}};

  state_t                  state;
  state_t                  state_nxt;
  logic [LEN_W-1:0]        len;
  logic [LEN_W-1:0]        len_nxt;
  logic                    eop_seen;
  logic                    eop_seen_nxt;
  logic                    wr_nxt;
  logic [DATA_WIDTH+2:0]   din_nxt;
  logic                    inc_pkt;
  logic                    inc_drop;
  logic                    inc_err;

  // Next-state and write decision from the current beat and the FIFO status.
  always_comb begin
    state_nxt    = state;
    len_nxt      = len;
    eop_seen_nxt = eop_seen;
    wr_nxt       = 1'b0;
    din_nxt      = '0;
    inc_pkt      = 1'b0;
    inc_drop     = 1'b0;
    inc_err      = 1'b0;
    case (state)
      IDLE, DROP: begin
        if (wr_vld && wr_sop) begin
          // A sop always resynchronises, even while discarding.
          if (fifo_almost_full) begin
            inc_drop  = 1'b1;
            state_nxt = wr_eop ? IDLE : DROP;
          end else begin
            wr_nxt  = 1'b1;
            din_nxt = {1'b0, 1'b1, wr_eop, wr_data};
            len_nxt = LEN_W'(1);
            if (wr_eop) begin
              inc_pkt   = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = PKT;
            end
          end
        end else if (wr_vld) begin
          if (state == IDLE) begin
            // Beat outside any packet.
            inc_err = 1'b1;
          end else if (wr_eop) begin
            state_nxt = IDLE;
          end
        end
      end
      PKT: begin
        if (wr_vld) begin
          if (wr_sop) begin
            // Missing eop: close the open packet and drop the new one.
            inc_err  = 1'b1;
            inc_drop = 1'b1;
            if (fifo_almost_full) begin
              eop_seen_nxt = wr_eop;
              state_nxt    = CLOSE;
            end else begin
              wr_nxt    = 1'b1;
              din_nxt   = CLOSE_WORD;
              state_nxt = wr_eop ? IDLE : DROP;
            end
          end else if (fifo_almost_full) begin
            // No room mid-packet: truncate and owe a closing word.
            inc_err      = 1'b1;
            eop_seen_nxt = wr_eop;
            state_nxt    = CLOSE;
          end else if (len == MAX_LEN_L) begin
            // Over-length: this beat becomes the error-eop word.
            wr_nxt    = 1'b1;
            din_nxt   = {1'b1, 1'b0, 1'b1, wr_data};
            inc_err   = 1'b1;
            state_nxt = wr_eop ? IDLE : DROP;
          end else begin
            wr_nxt  = 1'b1;
            din_nxt = {1'b0, 1'b0, wr_eop, wr_data};
            len_nxt = len + 1'b1;
            if (wr_eop) begin
              inc_pkt   = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      CLOSE: begin
        // Input beats are discarded here; only their eop is remembered.
        if (!fifo_almost_full) begin
          wr_nxt       = 1'b1;
          din_nxt      = CLOSE_WORD;
          eop_seen_nxt = 1'b0;
          state_nxt    = (eop_seen || (wr_vld && wr_eop)) ? IDLE : DROP;
        end else begin
          eop_seen_nxt = eop_seen | (wr_vld & wr_eop);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, length tracking and registered FIFO-side outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= IDLE;
      len        <= '0;
      eop_seen   <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_nxt;
      len        <= len_nxt;
      eop_seen   <= eop_seen_nxt;
      fifo_wr_en <= wr_nxt;
      err_pulse  <= inc_err | inc_drop;
      if (wr_nxt) begin
        fifo_din <= din_nxt;
      end
    end
  end

`ifdef PORT_FRAMER_STATS_EN
  logic [15:0] pkt_q;
  logic [15:0] drop_q;
  logic [15:0] err_q;

  // Saturating statistics counters, updated alongside err_pulse.
  always_ff @(posedge clk) begin
    if (srst) begin
      pkt_q  <= '0;
      drop_q <= '0;
      err_q  <= '0;
    end else begin
      if (inc_pkt && (pkt_q != 16'hFFFF)) begin
        pkt_q <= pkt_q + 16'd1;
      end
      if (inc_drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      if (inc_err && (err_q != 16'hFFFF)) begin
        err_q <= err_q + 16'd1;
      end
    end
  end

  assign pkt_cnt  = pkt_q;
  assign drop_cnt = drop_q;
  assign err_cnt  = err_q;
`else
  // Statistics not built; the clean-eop event has no other consumer.
  logic unused_stats;
  assign unused_stats = inc_pkt;
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule
